// File: rtl/alu_pkg.sv
// Shared op codes and default widths for the CPU ALU and its port scheduler.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 4;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_BEQ = 4'd7;
    localparam logic [3:0] ALU_BNE = 4'd8;
    localparam logic [3:0] ALU_BLT = 4'd9;
    localparam logic [3:0] ALU_BGE = 4'd10;
    localparam logic [3:0] ALU_NOP = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the port not granted last wins a tie.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic last_grant_r;

    // Grant selection from current eligibility and tie-break history.
    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // History register; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
        end else if (grant[0]) begin
            last_grant_r <= 1'b0;
        end else if (grant[1]) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one combinational ALU between an address port and an execute port.
module alu_share_sched
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result0,
    output logic [WIDTH-1:0] resp_result1,
    output logic             resp_bcond0,
    output logic             resp_bcond1,
    output logic [OPW-1:0]   alu_select,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_bcond
);

    logic [1:0]       eligible_s;
    logic [1:0]       grant_s;
    logic [1:0]       resp_valid_r;
    logic [WIDTH-1:0] result0_r;
    logic [WIDTH-1:0] result1_r;
    logic             bcond0_r;
    logic             bcond1_r;

    // A slot being drained this cycle may be refilled; nothing is eligible in reset.
    always_comb begin
        eligible_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eligible_s[i] = reset_n & req_valid[i] & (~resp_valid_r[i] | resp_ready[i]);
        end
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .eligible (eligible_s),
        .grant    (grant_s)
    );

    // Operand mux: winning port drives the ALU, otherwise idle NOP with zero operands.
    always_comb begin
        alu_select = {OPW{1'b1}};
        alu_in_1   = {WIDTH{1'b0}};
        alu_in_2   = {WIDTH{1'b0}};
        case (grant_s)
            2'b01: begin
                alu_select = req_op0;
                alu_in_1   = req_a0;
                alu_in_2   = req_b0;
            end
            2'b10: begin
                alu_select = req_op1;
                alu_in_1   = req_a1;
                alu_in_2   = req_b1;
            end
            default: begin
                alu_select = {OPW{1'b1}};
                alu_in_1   = {WIDTH{1'b0}};
                alu_in_2   = {WIDTH{1'b0}};
            end
        endcase
    end

    // Response registers: load on grant, clear valid on drain, data held otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_valid_r <= 2'b00;
            result0_r    <= {WIDTH{1'b0}};
            result1_r    <= {WIDTH{1'b0}};
            bcond0_r     <= 1'b0;
            bcond1_r     <= 1'b0;
        end else begin
            if (grant_s[0]) begin
                resp_valid_r[0] <= 1'b1;
                result0_r       <= alu_result;
                bcond0_r        <= alu_bcond;
            end else if (resp_ready[0]) begin
                resp_valid_r[0] <= 1'b0;
            end else begin
                resp_valid_r[0] <= resp_valid_r[0];
            end
            if (grant_s[1]) begin
                resp_valid_r[1] <= 1'b1;
                result1_r       <= alu_result;
                bcond1_r        <= alu_bcond;
            end else if (resp_ready[1]) begin
                resp_valid_r[1] <= 1'b0;
            end else begin
                resp_valid_r[1] <= resp_valid_r[1];
            end
        end
    end

    assign req_ready    = grant_s;
    assign resp_valid   = resp_valid_r;
    assign resp_result0 = result0_r;
    assign resp_result1 = result1_r;
    assign resp_bcond0  = bcond0_r;
    assign resp_bcond1  = bcond1_r;

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched with a behavioural ALU model attached.
module tb_alu_share_sched;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_op0, req_op1;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [W-1:0] resp_result0, resp_result1;
    logic         resp_bcond0, resp_bcond1;
    logic [3:0]   alu_select;
    logic [W-1:0] alu_in_1, alu_in_2;
    logic [W-1:0] alu_result;
    logic         alu_bcond;

    int checks = 0;
    int errors = 0;

    alu_share_sched #(.WIDTH(W), .OPW(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result0 (resp_result0),
        .resp_result1 (resp_result1),
        .resp_bcond0  (resp_bcond0),
        .resp_bcond1  (resp_bcond1),
        .alu_select   (alu_select),
        .alu_in_1     (alu_in_1),
        .alu_in_2     (alu_in_2),
        .alu_result   (alu_result),
        .alu_bcond    (alu_bcond)
    );

    // Reference ALU living outside the scheduler.
    always_comb begin
        alu_result = '0;
        alu_bcond  = 1'b0;
        case (alu_select)
            ALU_ADD: alu_result = alu_in_1 + alu_in_2;
            ALU_SUB: alu_result = alu_in_1 - alu_in_2;
            ALU_SLL: alu_result = alu_in_1 << alu_in_2[4:0];
            ALU_XOR: alu_result = alu_in_1 ^ alu_in_2;
            ALU_OR:  alu_result = alu_in_1 | alu_in_2;
            ALU_AND: alu_result = alu_in_1 & alu_in_2;
            ALU_SRL: alu_result = alu_in_1 >> alu_in_2[4:0];
            ALU_BEQ: alu_bcond  = (alu_in_1 == alu_in_2);
            ALU_BNE: alu_bcond  = (alu_in_1 != alu_in_2);
            ALU_BLT: alu_bcond  = ($signed(alu_in_1) < $signed(alu_in_2));
            ALU_BGE: alu_bcond  = ($signed(alu_in_1) >= $signed(alu_in_2));
            default: begin
                alu_result = '0;
                alu_bcond  = 1'b0;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 2'b00;
        req_op0 = ALU_ADD; req_a0 = 32'd1; req_b0 = 32'd2;
        req_op1 = ALU_ADD; req_a1 = 32'd3; req_b1 = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_result0", resp_result0, 32'd0);
        check("rst_bcond1", resp_bcond1, 1'b0);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_alu_select", alu_select, 4'hF);
        check("rst_alu_in_1", alu_in_1, 32'd0);

        // Contention: SUB 10-3 on port 0, BEQ 4,4 on port 1, grants 0,1,0,1.
        @(negedge clk);
        reset_n = 1'b1; req_valid = 2'b11; resp_ready = 2'b11;
        req_op0 = ALU_SUB; req_a0 = 32'd10; req_b0 = 32'd3;
        req_op1 = ALU_BEQ; req_a1 = 32'd4;  req_b1 = 32'd4;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            check("rr_req_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_alu_select", alu_select, (k % 2 == 0) ? 4'd1 : 4'd7);
            @(posedge clk); #1;
            check("rr_resp_valid", resp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) begin
                check("rr_result0", resp_result0, 32'd7);
                check("rr_bcond0", resp_bcond0, 1'b0);
            end else begin
                check("rr_result1", resp_result1, 32'd0);
                check("rr_bcond1", resp_bcond1, 1'b1);
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("rr_drained", resp_valid, 2'b00);

        // Single-port ADD 5+7.
        @(negedge clk);
        req_valid = 2'b01; req_op0 = ALU_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
        #1;
        check("add_req_ready", req_ready, 2'b01);
        check("add_alu_select", alu_select, 4'd0);
        check("add_alu_in_2", alu_in_2, 32'd7);
        @(posedge clk); #1;
        check("add_resp_valid", resp_valid, 2'b01);
        check("add_result0", resp_result0, 32'd12);
        check("add_bcond0", resp_bcond0, 1'b0);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("idle_alu_select", alu_select, 4'hF);
        @(posedge clk); #1;
        check("add_drained", resp_valid, 2'b00);
        check("add_result_kept", resp_result0, 32'd12);

        // Backpressure on port 1 after XOR 0xF0^0x0F.
        @(negedge clk);
        req_valid = 2'b10; resp_ready = 2'b00;
        req_op1 = ALU_XOR; req_a1 = 32'hF0; req_b1 = 32'h0F;
        #1;
        check("bp_first_grant", req_ready, 2'b10);
        @(posedge clk); #1;
        check("bp_result1", resp_result1, 32'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 2'b11; resp_ready = 2'b01;
            req_op0 = ALU_ADD; req_a0 = 32'(k + 20); req_b0 = 32'd1;
            req_op1 = ALU_OR;  req_a1 = 32'd1;       req_b1 = 32'd2;
            #1;
            check("bp_req_ready", req_ready, 2'b01);
            @(posedge clk); #1;
            check("bp_held1", resp_result1, 32'hFF);
            check("bp_result0", resp_result0, 32'(k + 21));
            check("bp_resp_valid", resp_valid, 2'b11);
        end
        @(negedge clk);
        resp_ready = 2'b11;
        #1;
        check("bp_release_grant", req_ready, 2'b10);
        @(posedge clk); #1;
        check("bp_new_result1", resp_result1, 32'd3);
        check("bp_release_valid", resp_valid, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("bp_drained", resp_valid, 2'b00);

        // Port 1 then undefined op 4'hD on port 0, both left pending.
        @(negedge clk);
        req_valid = 2'b10; resp_ready = 2'b00;
        req_op1 = ALU_ADD; req_a1 = 32'd1; req_b1 = 32'd1;
        @(posedge clk); #1;
        check("p1_result1", resp_result1, 32'd2);
        @(negedge clk);
        req_valid = 2'b01;
        req_op0 = 4'hD; req_a0 = 32'd123; req_b0 = 32'd45;
        #1;
        check("nop_alu_select", alu_select, 4'hD);
        @(posedge clk); #1;
        check("nop_result0", resp_result0, 32'd0);
        check("nop_bcond0", resp_bcond0, 1'b0);
        check("nop_resp_valid", resp_valid, 2'b11);

        // Reset with both responses pending; tie afterwards goes to port 0.
        @(negedge clk);
        reset_n = 1'b0; req_valid = 2'b11;
        #1;
        check("mrst_req_ready", req_ready, 2'b00);
        check("mrst_alu_select", alu_select, 4'hF);
        check("mrst_alu_in_2", alu_in_2, 32'd0);
        @(posedge clk); #1;
        check("mrst_resp_valid", resp_valid, 2'b00);
        check("mrst_result1", resp_result1, 32'd0);
        @(negedge clk);
        reset_n = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
        req_op0 = ALU_ADD; req_a0 = 32'd5; req_b0 = 32'd6;
        #1;
        check("mrst_tie_port0", req_ready, 2'b01);
        @(posedge clk); #1;
        check("mrst_after_result0", resp_result0, 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
